// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU and its two-requester arbiter.
// Covers ALUControl codes, flag bit positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] ALU_SUB      = 4'b0001;
    localparam logic [3:0] ALU_AND      = 4'b0010;
    localparam logic [3:0] ALU_OR       = 4'b0011;
    localparam logic [3:0] ALU_XOR      = 4'b0100;
    localparam logic [3:0] ALU_SLT      = 4'b0101;
    localparam logic [3:0] ALU_SLTU     = 4'b0110;
    localparam logic [3:0] ALU_SLL      = 4'b0111;
    localparam logic [3:0] ALU_SRL      = 4'b1000;
    localparam logic [3:0] ALU_SRA      = 4'b1001;
    localparam logic [3:0] ALU_CTRL_MAX = 4'b1001;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    function automatic logic ctrl_is_legal(input logic [3:0] ctrl);
        return (ctrl <= ALU_CTRL_MAX);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU producing a 32-bit result and {C, V, Z, N} flags.
// Carry and overflow are meaningful only for ADD/SUB; SUB carry means "no borrow".
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic [31:0] result_s;
    logic        carry_s;
    logic        ovf_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} + {1'b0, ~b} + 33'd1;

    // Operation select and carry/overflow generation
    always_comb begin
        result_s = 32'd0;
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                result_s = sum_s[31:0];
                carry_s  = sum_s[32];
                ovf_s    = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            ALU_SUB: begin
                result_s = diff_s[31:0];
                carry_s  = diff_s[32];
                ovf_s    = (a[31] != b[31]) && (diff_s[31] != a[31]);
            end
            ALU_AND:  result_s = a & b;
            ALU_OR:   result_s = a | b;
            ALU_XOR:  result_s = a ^ b;
            ALU_SLT:  result_s = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: result_s = {31'd0, (a < b)};
            ALU_SLL:  result_s = a << b[4:0];
            ALU_SRL:  result_s = a >> b[4:0];
            ALU_SRA:  result_s = $signed(a) >>> b[4:0];
            default:  result_s = 32'd0;
        endcase
    end

    assign result         = result_s;
    assign flags[FLAG_C]  = carry_s;
    assign flags[FLAG_V]  = ovf_s;
    assign flags[FLAG_Z]  = (result_s == 32'd0);
    assign flags[FLAG_N]  = result_s[31];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and one-deep sequencer sharing a single ALU between two requesters.
// Accepts one operation, holds its registered result until the owner takes the response.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [3:0]  req_ctrl_0,
    input  logic [3:0]  req_ctrl_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [15:0] grant_cnt_0,
    output logic [15:0] grant_cnt_1
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic        owner_r;
    logic        last_grant_r;
    logic        winner_s;
    logic        req_ready_0_s;
    logic        req_ready_1_s;
    logic        accept_s;
    logic        rsp_fire_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [3:0]  alu_ctrl_s;
    logic [31:0] alu_result_s;
    logic [3:0]  alu_flags_s;
    logic        legal_s;
    logic        rsp_valid_0_r;
    logic        rsp_valid_1_r;
    logic [31:0] rsp_result_r;
    logic [3:0]  rsp_flags_r;
    logic        rsp_err_r;
    logic [15:0] grant_cnt_0_r;
    logic [15:0] grant_cnt_1_r;

    // Round-robin winner: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        winner_s = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            winner_s = ~last_grant_r;
        end else if (req_valid_1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign req_ready_0_s = !rst && (state_r == ST_IDLE) && req_valid_0 && !winner_s;
    assign req_ready_1_s = !rst && (state_r == ST_IDLE) && req_valid_1 && winner_s;
    assign accept_s      = req_ready_0_s || req_ready_1_s;
    assign rsp_fire_s    = (state_r == ST_RESP) && (owner_r ? rsp_ready_1 : rsp_ready_0);

    assign alu_a_s    = winner_s ? req_a_1    : req_a_0;
    assign alu_b_s    = winner_s ? req_b_1    : req_b_0;
    assign alu_ctrl_s = winner_s ? req_ctrl_1 : req_ctrl_0;
    assign legal_s    = ctrl_is_legal(alu_ctrl_s);

    alu u_alu (
        .a           (alu_a_s),
        .b           (alu_b_s),
        .alu_control (alu_ctrl_s),
        .result      (alu_result_s),
        .flags       (alu_flags_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: hold a response until its owner takes it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_RESP;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RESP: begin
                if (rsp_fire_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Response capture, ownership and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            rsp_valid_0_r <= 1'b0;
            rsp_valid_1_r <= 1'b0;
            rsp_result_r  <= 32'd0;
            rsp_flags_r   <= 4'd0;
            rsp_err_r     <= 1'b0;
        end else if (accept_s) begin
            owner_r       <= winner_s;
            last_grant_r  <= winner_s;
            rsp_valid_0_r <= ~winner_s;
            rsp_valid_1_r <= winner_s;
            rsp_result_r  <= legal_s ? alu_result_s : 32'd0;
            rsp_flags_r   <= legal_s ? alu_flags_s  : 4'd0;
            rsp_err_r     <= ~legal_s;
        end else if (rsp_fire_s) begin
            rsp_valid_0_r <= 1'b0;
            rsp_valid_1_r <= 1'b0;
        end
    end

    // Saturating per-requester grant counters
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_0_r <= 16'd0;
            grant_cnt_1_r <= 16'd0;
        end else begin
            if (req_ready_0_s && (grant_cnt_0_r != 16'hFFFF)) begin
                grant_cnt_0_r <= grant_cnt_0_r + 16'd1;
            end
            if (req_ready_1_s && (grant_cnt_1_r != 16'hFFFF)) begin
                grant_cnt_1_r <= grant_cnt_1_r + 16'd1;
            end
        end
    end

    assign req_ready_0 = req_ready_0_s;
    assign req_ready_1 = req_ready_1_s;
    assign rsp_valid_0 = rsp_valid_0_r;
    assign rsp_valid_1 = rsp_valid_1_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_flags   = rsp_flags_r;
    assign rsp_err     = rsp_err_r;
    assign grant_cnt_0 = grant_cnt_0_r;
    assign grant_cnt_1 = grant_cnt_1_r;

endmodule
